rou_table_buffer: RTL and testbench

- One NTT/iNTT twiddle-factor (ROU) table sitting directly downstream of the BAR1 AXI-Lite programming slave.
- Consumes that slave's column-granular write port (one COL_WIDTH half-word per write, column-select write enables).
- Serves full-line reads to one NTT stage through a fixed 2-cycle read pipeline.
- Tracks load progress and flags reads issued before the table is fully programmed.

---
 rtl/rou_table_buffer.sv | 111 +++++++++++
 tb/tb_rou_table_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rou_table_buffer.sv
// rou_table_buffer: column-programmed NTT twiddle (ROU) table with a 2-cycle line read pipeline and load tracking.
// Optional macro ROU_TABLE_WR_FWD_EN merges same-line writes into in-flight reads (default: read-first).
module rou_table_buffer #(
    parameter int DEPTH      = 1024,
    parameter int LINE_SIZE  = 2,
    parameter int BIT_WIDTH  = 54,
    parameter int COL_WIDTH  = BIT_WIDTH/2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clear,
    input  logic [LINE_SIZE*2-1:0]                  wr_we,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [COL_WIDTH-1:0]                    wr_din,
    input  logic                                    rd_en,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr,
    output logic [LINE_SIZE*BIT_WIDTH-1:0]          rd_data,
    output logic                                    rd_valid,
    output logic                                    rd_err,
    output logic                                    table_ready,
    output logic [$clog2(DEPTH*LINE_SIZE*2+1)-1:0]  wr_count
);
    localparam int NCOL  = LINE_SIZE*2;
    localparam int TOTAL = DEPTH*NCOL;
    localparam int CW    = $clog2(TOTAL+1);
    localparam int LW    = LINE_SIZE*BIT_WIDTH;

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t          r_state, w_state_nxt;
    logic [LW-1:0]   r_mem [DEPTH];
    logic [LW-1:0]   r_s1_data, w_rd_line, w_s2_line;
    logic            r_s1_v, r_s1_err;
    logic [CW-1:0]   w_pop, w_cnt_nxt;
    logic [CW:0]     w_sum;

    always_ff @(posedge clk) begin
        if (!rst)
            for (int c = 0; c < NCOL; c++)
                if (wr_we[c]) r_mem[wr_addr][c*COL_WIDTH +: COL_WIDTH] <= wr_din;
    end

`ifdef ROU_TABLE_WR_FWD_EN
    logic [ADDR_WIDTH-1:0] r_s1_addr;

    function automatic logic [LW-1:0] merge(input logic [LW-1:0] line, input logic [NCOL-1:0] we,
                                            input logic [COL_WIDTH-1:0] din);
        merge = line;
        for (int c = 0; c < NCOL; c++)
            if (we[c]) merge[c*COL_WIDTH +: COL_WIDTH] = din;
    endfunction

    // Same-cycle write merges into stage 1; a write one cycle later merges into stage 2.
    assign w_rd_line = (wr_addr == rd_addr) ? merge(r_mem[rd_addr], wr_we, wr_din) : r_mem[rd_addr];
    assign w_s2_line = (wr_addr == r_s1_addr) ? merge(r_s1_data, wr_we, wr_din) : r_s1_data;

    always_ff @(posedge clk) begin
        if (rd_en) r_s1_addr <= rd_addr;
    end
`else
    assign w_rd_line = r_mem[rd_addr];
    assign w_s2_line = r_s1_data;
`endif

    always_ff @(posedge clk) begin
        if (rd_en) r_s1_data <= w_rd_line;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_err <= 1'b0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            r_s1_v   <= rd_en;
            r_s1_err <= rd_en & ~table_ready;
            rd_valid <= r_s1_v;
            rd_err   <= r_s1_v & r_s1_err;
            if (r_s1_v) rd_data <= w_s2_line;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NCOL; c++) w_pop = w_pop + CW'(wr_we[c]);
        w_sum       = {1'b0, wr_count} + {1'b0, w_pop};
        w_cnt_nxt   = (w_sum >= (CW+1)'(TOTAL)) ? CW'(TOTAL) : w_sum[CW-1:0];
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = EMPTY;
            w_cnt_nxt   = '0;
        end else if (r_state != READY && wr_we != '0) begin
            w_state_nxt = (w_cnt_nxt == CW'(TOTAL)) ? READY : LOADING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            wr_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            wr_count <= w_cnt_nxt;
        end
    end

    assign table_ready = (r_state == READY);
endmodule

// File: tb/tb_rou_table_buffer.sv
// tb_rou_table_buffer: directed checks of load tracking, read latency/throughput, clear and reset behaviour.
module tb_rou_table_buffer;
    localparam int CWD = 27;

    logic         clk = 1'b0;
    logic         rst, clear, rd_en;
    logic [3:0]   wr_we;
    logic [1:0]   wr_addr, rd_addr;
    logic [26:0]  wr_din;
    logic [107:0] rd_data;
    logic         rd_valid, rd_err, table_ready;
    logic [4:0]   wr_count;

    int errors = 0;
    int checks = 0;
    int nwr = 0;
    logic [107:0] exp_line;

    rou_table_buffer #(.DEPTH(4), .LINE_SIZE(2), .BIT_WIDTH(54)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_we(wr_we), .wr_addr(wr_addr), .wr_din(wr_din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .table_ready(table_ready), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [107:0] line_val(input int l);
        return {CWD'(l*4+3), CWD'(l*4+2), CWD'(l*4+1), CWD'(l*4)};
    endfunction

    task automatic wr(input int l, input int c, input logic [26:0] v);
        wr_we   = 4'(1 << c);
        wr_addr = 2'(l);
        wr_din  = v;
        cyc();
        wr_we   = '0;
        nwr++;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; rd_en = 1'b0; wr_we = '0;
        wr_addr = '0; rd_addr = '0; wr_din = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_valid", 128'(rd_valid), 128'(0));
        chk("rst_err", 128'(rd_err), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        chk("rst_ready", 128'(table_ready), 128'(0));
        chk("rst_count", 128'(wr_count), 128'(0));

        // Partial load, then an early read flagged with rd_err
        for (int c = 0; c < 3; c++) wr(1, c, CWD'(4 + c));
        rd_en = 1'b1; rd_addr = 2'd1;
        cyc();
        rd_en = 1'b0;
        chk("early_n1_valid", 128'(rd_valid), 128'(0));
        cyc();
        chk("early_valid", 128'(rd_valid), 128'(1));
        chk("early_err", 128'(rd_err), 128'(1));
        chk("early_ready", 128'(table_ready), 128'(0));
        chk("early_count", 128'(wr_count), 128'(3));

        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 4; c++) begin
                if (!(l == 1 && c < 3)) begin
                    wr(l, c, CWD'(l*4 + c));
                    if (nwr == 15) begin
                        chk("cnt15", 128'(wr_count), 128'(15));
                        chk("ready15", 128'(table_ready), 128'(0));
                    end
                end
            end
        chk("cnt16", 128'(wr_count), 128'(16));
        chk("ready16", 128'(table_ready), 128'(1));

        // Single read: exactly two cycles of latency
        rd_en = 1'b1; rd_addr = 2'd2;
        cyc();
        rd_en = 1'b0;
        chk("rd2_n1_valid", 128'(rd_valid), 128'(0));
        cyc();
        chk("rd2_valid", 128'(rd_valid), 128'(1));
        chk("rd2_data", 128'(rd_data), 128'(line_val(2)));
        chk("rd2_err", 128'(rd_err), 128'(0));
        cyc();
        chk("rd2_drop", 128'(rd_valid), 128'(0));
        chk("rd2_hold", 128'(rd_data), 128'(line_val(2)));

        // Back-to-back burst over all lines
        for (int i = 0; i < 6; i++) begin
            rd_en   = (i < 4);
            rd_addr = 2'(i);
            cyc();
            chk($sformatf("burst%0d_valid", i), 128'(rd_valid), 128'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) begin
                chk($sformatf("burst%0d_data", i), 128'(rd_data), 128'(line_val(i - 1)));
                chk($sformatf("burst%0d_err", i), 128'(rd_err), 128'(0));
            end
        end

        // Same-cycle read and write to line 3 column 1
        rd_en = 1'b1; rd_addr = 2'd3;
        wr_we = 4'b0010; wr_addr = 2'd3; wr_din = 27'h1234567;
        cyc();
        rd_en = 1'b0; wr_we = '0;
        cyc();
        exp_line = line_val(3);
`ifdef ROU_TABLE_WR_FWD_EN
        exp_line[CWD +: CWD] = 27'h1234567;
`endif
        chk("rdw_data", 128'(rd_data), 128'(exp_line));
        chk("rdw_count", 128'(wr_count), 128'(16));
        chk("rdw_ready", 128'(table_ready), 128'(1));
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        cyc();
        exp_line = line_val(3);
        exp_line[CWD +: CWD] = 27'h1234567;
        chk("rdw_after", 128'(rd_data), 128'(exp_line));

        // Clear with a concurrent write: write lands, clear wins for tracking
        clear = 1'b1; wr_we = 4'b0001; wr_addr = 2'd0; wr_din = 27'h5A5A5A;
        cyc();
        clear = 1'b0; wr_we = '0;
        chk("clr_ready", 128'(table_ready), 128'(0));
        chk("clr_count", 128'(wr_count), 128'(0));
        rd_en = 1'b1; rd_addr = 2'd0;
        cyc();
        rd_en = 1'b0;
        cyc();
        chk("clr_rd_valid", 128'(rd_valid), 128'(1));
        chk("clr_rd_col0", 128'(rd_data[0 +: CWD]), 128'(27'h5A5A5A));
        chk("clr_rd_col1", 128'(rd_data[CWD +: CWD]), 128'(27'd1));
        chk("clr_rd_err", 128'(rd_err), 128'(1));

        // Reset one cycle after rd_en drops the in-flight read
        wr(2, 0, 27'h7);
        chk("pre_rst_count", 128'(wr_count), 128'(1));
        rd_en = 1'b1; rd_addr = 2'd2;
        cyc();
        rd_en = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rrst_valid", 128'(rd_valid), 128'(0));
        chk("rrst_data", 128'(rd_data), 128'(0));
        chk("rrst_err", 128'(rd_err), 128'(0));
        chk("rrst_count", 128'(wr_count), 128'(0));
        chk("rrst_ready", 128'(table_ready), 128'(0));
        cyc();
        chk("rrst_valid2", 128'(rd_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
